bcd_scan_display: RTL and testbench

Four-digit time-multiplexed 7-segment driver that sits directly downstream of the two-digit BCD counter pairs in the digital clock datapath. It consumes the `unit`/`tens` BCD outputs of the minutes and seconds counters, captures them coherently once per scan frame, and drives the shared segment bus and per-digit enables. Optional digit blinking supports the time-setting mode.

---
 rtl/bcd_scan_display_pkg.sv | 31 +++
 rtl/bcd_scan_display_bcd_to_ssd.sv | 33 +++
 rtl/bcd_scan_display.sv | 138 +++++++++++++
 tb/tb_bcd_scan_display.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bcd_scan_display_pkg.sv
// Shared constants and helpers for the four-digit multiplexed 7-segment driver.
// Segment patterns are active low, ordered {a,b,c,d,e,f,g,dp}.
package bcd_scan_display_pkg;

    localparam int BCD_BIT_WIDTH = 4;

    localparam logic ENABLED  = 1'b0;
    localparam logic DISABLED = 1'b1;

    localparam logic [7:0] SS_0     = 8'b0000_0011;
    localparam logic [7:0] SS_1     = 8'b1001_1111;
    localparam logic [7:0] SS_2     = 8'b0010_0101;
    localparam logic [7:0] SS_3     = 8'b0000_1101;
    localparam logic [7:0] SS_4     = 8'b1001_1001;
    localparam logic [7:0] SS_5     = 8'b0100_1001;
    localparam logic [7:0] SS_6     = 8'b0100_0001;
    localparam logic [7:0] SS_7     = 8'b0001_1111;
    localparam logic [7:0] SS_8     = 8'b0000_0001;
    localparam logic [7:0] SS_9     = 8'b0000_1001;
    localparam logic [7:0] SS_DASH  = 8'b1111_1101;
    localparam logic [7:0] SS_BLANK = 8'b1111_1111;

    // Active-low one-hot digit enable for the given slot.
    function automatic logic [3:0] digit_enable(input logic [1:0] idx);
        logic [3:0] ctl;
        ctl      = {4{DISABLED}};
        ctl[idx] = ENABLED;
        return ctl;
    endfunction

endpackage

// File: rtl/bcd_scan_display_bcd_to_ssd.sv
// Combinational BCD + decimal point to active-low 7-segment decoder.
// Non-BCD codes (10..15) show a dash so a corrupted counter is visible.
module bcd_to_ssd
    import bcd_scan_display_pkg::*;
(
    input  logic [BCD_BIT_WIDTH-1:0] bcd,
    input  logic                     dp,
    output logic [7:0]               seg
);

    logic [7:0] pattern_s;

    // Digit pattern lookup with dp bit forced off.
    always_comb begin
        pattern_s = SS_DASH;
        case (bcd)
            4'd0:    pattern_s = SS_0;
            4'd1:    pattern_s = SS_1;
            4'd2:    pattern_s = SS_2;
            4'd3:    pattern_s = SS_3;
            4'd4:    pattern_s = SS_4;
            4'd5:    pattern_s = SS_5;
            4'd6:    pattern_s = SS_6;
            4'd7:    pattern_s = SS_7;
            4'd8:    pattern_s = SS_8;
            4'd9:    pattern_s = SS_9;
            default: pattern_s = SS_DASH;
        endcase
    end

    assign seg = {pattern_s[7:1], ~dp};

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit time-multiplexed 7-segment driver with per-frame coherent snapshot.
// Optional digit blinking is enabled by defining BCD_SCAN_BLINK_EN.
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYC    = 4,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  ssd_ctl,
    output logic [7:0]  ssd_seg
);

    localparam int             CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD    = CNT_W'(GUARD_CYC);

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       idx_r;
    logic [15:0]      digits_r;
    logic [3:0]       dp_r;
    logic             slot_end_s;
    logic             frame_end_s;
    logic             blank_digit_s;
    logic [3:0]       cur_bcd_s;
    logic             cur_dp_s;
    logic [7:0]       dec_seg_s;
    logic [3:0]       next_ctl_s;
    logic [7:0]       next_seg_s;

    assign slot_end_s  = (cnt_r == CNT_LAST);
    assign frame_end_s = slot_end_s && (idx_r == 2'd3);

    // Slot prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Frame snapshot: the whole display updates only between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_r <= 16'h0000;
            dp_r     <= 4'b0000;
        end else if (frame_end_s) begin
            digits_r <= digits;
            dp_r     <= dp_mask;
        end
    end

`ifdef BCD_SCAN_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0] frame_cnt_r;
    logic            phase_r;
    logic [3:0]      blink_r;

    // Blink frame counter, phase toggle and mask snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= '0;
            phase_r     <= 1'b0;
            blink_r     <= 4'b0000;
        end else if (frame_end_s) begin
            blink_r <= blink_mask;
            if (frame_cnt_r == FR_LAST) begin
                frame_cnt_r <= '0;
                phase_r     <= ~phase_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + FR_W'(1);
            end
        end
    end

    assign blank_digit_s = phase_r && blink_r[idx_r];
`else
    logic unused_blink_s;
    assign unused_blink_s = ^blink_mask;
    assign blank_digit_s  = 1'b0;
`endif

    // Shadow digit and dp selection for the active slot.
    always_comb begin
        cur_bcd_s = digits_r[3:0];
        cur_dp_s  = dp_r[0];
        case (idx_r)
            2'd0:    begin cur_bcd_s = digits_r[3:0];   cur_dp_s = dp_r[0]; end
            2'd1:    begin cur_bcd_s = digits_r[7:4];   cur_dp_s = dp_r[1]; end
            2'd2:    begin cur_bcd_s = digits_r[11:8];  cur_dp_s = dp_r[2]; end
            2'd3:    begin cur_bcd_s = digits_r[15:12]; cur_dp_s = dp_r[3]; end
            default: begin cur_bcd_s = digits_r[3:0];   cur_dp_s = dp_r[0]; end
        endcase
    end

    bcd_to_ssd u_dec (
        .bcd (cur_bcd_s),
        .dp  (cur_dp_s),
        .seg (dec_seg_s)
    );

    // Guard interval and blink blanking, otherwise drive the active digit.
    always_comb begin
        next_ctl_s = {4{DISABLED}};
        next_seg_s = SS_BLANK;
        if ((cnt_r < GUARD) || blank_digit_s) begin
            next_ctl_s = {4{DISABLED}};
            next_seg_s = SS_BLANK;
        end else begin
            next_ctl_s = digit_enable(idx_r);
            next_seg_s = dec_seg_s;
        end
    end

    // Registered outputs; one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ssd_ctl <= {4{DISABLED}};
            ssd_seg <= SS_BLANK;
        end else begin
            ssd_ctl <= next_ctl_s;
            ssd_seg <= next_seg_s;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with SCAN_DIV=8, GUARD_CYC=2, BLINK_FRAMES=2.
module tb_bcd_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  ssd_ctl;
    logic [7:0]  ssd_seg;

    int n_total = 0;
    int n_pass  = 0;
    int ecount  = 0;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0][7:0] seg;
    } vec_t;

    vec_t vecs [4];

    bcd_scan_display #(.SCAN_DIV(8), .GUARD_CYC(2), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .ssd_ctl    (ssd_ctl),
        .ssd_seg    (ssd_seg)
    );

    always #5 clk = ~clk;

    // Edge index since reset release; outputs after edge k reflect cnt/idx of step k.
    always @(posedge clk) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    task automatic cmp(input string name, input logic [3:0] ectl, input logic [7:0] eseg);
        n_total++;
        if (ssd_ctl === ectl && ssd_seg === eseg) n_pass++;
        else $display("FAIL %s: ctl=%b seg=%b, required ctl=%b seg=%b", name, ssd_ctl, ssd_seg, ectl, eseg);
    endtask

    task automatic at_edge(input int k);
        int guard = 0;
        if (ecount - 1 > k) begin
            n_total++;
            $display("FAIL sched: at edge %0d, required edge %0d", ecount - 1, k);
        end
        while (ecount - 1 < k && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic chk(input string name, input int k, input logic [3:0] ectl, input logic [7:0] eseg);
        at_edge(k);
        cmp(name, ectl, eseg);
    endtask

    function automatic logic [3:0] en(input int i);
        logic [3:0] c;
        c = 4'b1111;
        c[i] = 1'b0;
        return c;
    endfunction

    initial begin
        vecs[0].digits = 16'h1259; vecs[0].dp = 4'b0000;
        vecs[0].seg = {8'h9F, 8'h25, 8'h49, 8'h09};
        vecs[1].digits = 16'h00A0; vecs[1].dp = 4'b0000;
        vecs[1].seg = {8'h03, 8'h03, 8'hFD, 8'h03};
        vecs[2].digits = 16'h1234; vecs[2].dp = 4'b0100;
        vecs[2].seg = {8'h9F, 8'h24, 8'h0D, 8'h99};
        vecs[3].digits = 16'h8076; vecs[3].dp = 4'b1111;
        vecs[3].seg = {8'h00, 8'h02, 8'h1E, 8'h40};

        rst = 1'b1; digits = 16'h1259; dp_mask = 4'b0000; blink_mask = 4'b0000;
        repeat (3) @(negedge clk);
        cmp("reset", 4'b1111, 8'hFF);
        rst = 1'b0;

        // Frame 0 shows the cleared shadow.
        chk("f0_guard", 0, 4'b1111, 8'hFF);
        chk("f0_d0", 2, 4'b1110, 8'h03);
        chk("f0_d1", 10, 4'b1101, 8'h03);

        // Table: vector v is loaded during frame 2v+1 and displayed in frame 2v+2.
        for (int v = 0; v < 4; v++) begin
            int f;
            f = 2 * v + 2;
            at_edge(32 * (f - 1));
            digits = vecs[v].digits;
            dp_mask = vecs[v].dp;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("v%0d_d%0d_guard", v, i), 32 * f + 8 * i + 1, 4'b1111, 8'hFF);
                chk($sformatf("v%0d_d%0d_first", v, i), 32 * f + 8 * i + 2, en(i), vecs[v].seg[i]);
                chk($sformatf("v%0d_d%0d_last", v, i), 32 * f + 8 * i + 7, en(i), vecs[v].seg[i]);
            end
        end

        // Coherency: mid-frame change does not tear the displayed frame.
        dp_mask = 4'b0000;
        at_edge(32 * 9);
        digits = 16'h0959;
        at_edge(320 + 12);
        digits = 16'h1000;
        chk("coh_old_d2", 320 + 18, 4'b1011, 8'h09);
        chk("coh_old_d3", 320 + 26, 4'b0111, 8'h03);
        chk("coh_new_d0", 352 + 2, 4'b1110, 8'h03);
        chk("coh_new_d1", 352 + 10, 4'b1101, 8'h03);
        chk("coh_new_d2", 352 + 18, 4'b1011, 8'h03);
        chk("coh_new_d3", 352 + 26, 4'b0111, 8'h9F);

        // Snapshot edge: change present at edge 383 is captured, one later waits a frame.
        at_edge(382);
        digits = 16'h2222;
        at_edge(383);
        digits = 16'h4444;
        chk("snap_on_edge", 384 + 2, 4'b1110, 8'h25);
        chk("snap_late", 416 + 2, 4'b1110, 8'h99);

        // Mid-slot reset: blank on the next edge, index restarts, shadow cleared.
        at_edge(428);
        rst = 1'b1;
        blink_mask = 4'b0011;
        @(negedge clk);
        cmp("midrst_blank", 4'b1111, 8'hFF);
        repeat (2) @(negedge clk);
        cmp("midrst_hold", 4'b1111, 8'hFF);
        rst = 1'b0;
        chk("midrst_d0", 2, 4'b1110, 8'h03);
        chk("midrst_d1", 10, 4'b1101, 8'h03);

        // Blink: digits 0-1 blank in frames 2,3 with BLINK_FRAMES=2; digit 2 always lit.
        for (int f = 1; f <= 5; f++) begin
            logic blanked;
            blanked = 1'b0;
`ifdef BCD_SCAN_BLINK_EN
            blanked = (f == 2 || f == 3);
`endif
            if (blanked) chk($sformatf("blink_f%0d_d0", f), 32 * f + 2, 4'b1111, 8'hFF);
            else         chk($sformatf("blink_f%0d_d0", f), 32 * f + 2, 4'b1110, 8'h99);
            chk($sformatf("blink_f%0d_d2", f), 32 * f + 18, 4'b1011, 8'h99);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
